// File: rtl/melody_pkg.sv
// Shared types, note codes and the note-to-divider-limit mapping for the melody sequencer.
package melody_pkg;

   localparam int CODE_W  = 4;
   localparam int DUR_W   = 4;
   localparam int ENTRY_W = CODE_W + DUR_W;
   localparam int LIMIT_W = 28;
   localparam int MAX_LEN = 16;

   localparam logic [CODE_W-1:0] NOTE_REST = 4'd0;
   localparam logic [CODE_W-1:0] NOTE_C4   = 4'd1;
   localparam logic [CODE_W-1:0] NOTE_CS4  = 4'd2;
   localparam logic [CODE_W-1:0] NOTE_D4   = 4'd3;
   localparam logic [CODE_W-1:0] NOTE_DS4  = 4'd4;
   localparam logic [CODE_W-1:0] NOTE_E4   = 4'd5;
   localparam logic [CODE_W-1:0] NOTE_F4   = 4'd6;
   localparam logic [CODE_W-1:0] NOTE_FS4  = 4'd7;
   localparam logic [CODE_W-1:0] NOTE_G4   = 4'd8;
   localparam logic [CODE_W-1:0] NOTE_GS4  = 4'd9;
   localparam logic [CODE_W-1:0] NOTE_A4   = 4'd10;
   localparam logic [CODE_W-1:0] NOTE_AS4  = 4'd11;
   localparam logic [CODE_W-1:0] NOTE_B4   = 4'd12;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2
   } state_t;

   typedef struct packed {
      logic [CODE_W-1:0] code;
      logic [DUR_W-1:0]  dur;
   } entry_t;

   // Entry i lives at bits [i*8 +: 8]; the first note is the rightmost byte.
   localparam logic [MAX_LEN*ENTRY_W-1:0] DEFAULT_SONG = {
      8'h00, 8'h00, 8'h12, 8'h31, 8'h31, 8'h51, 8'h51, 8'h61,
      8'h61, 8'h82, 8'hA1, 8'hA1, 8'h81, 8'h81, 8'h11, 8'h11
   };

   function automatic logic is_tone(input logic [CODE_W-1:0] code);
      return (code >= NOTE_C4) && (code <= NOTE_B4);
   endfunction

   // Equal-temperament pitches in micro-hertz so integer rounding stays exact.
   function automatic longint unsigned note_freq_uhz(input logic [CODE_W-1:0] code);
      case (code)
         NOTE_C4:  return 64'd261625565;
         NOTE_CS4: return 64'd277182631;
         NOTE_D4:  return 64'd293664768;
         NOTE_DS4: return 64'd311126984;
         NOTE_E4:  return 64'd329627557;
         NOTE_F4:  return 64'd349228231;
         NOTE_FS4: return 64'd369994423;
         NOTE_G4:  return 64'd391995436;
         NOTE_GS4: return 64'd415304698;
         NOTE_A4:  return 64'd440000000;
         NOTE_AS4: return 64'd466163762;
         NOTE_B4:  return 64'd493883301;
         default:  return 64'd0;
      endcase
   endfunction

   function automatic logic [LIMIT_W-1:0] note_limit(input logic [CODE_W-1:0] code,
                                                     input longint unsigned clk_hz);
      longint unsigned f_uhz;
      longint unsigned half;
      f_uhz = note_freq_uhz(code);
      if (f_uhz == 64'd0) return '0;
      half = (clk_hz * 64'd1000000 + f_uhz) / (64'd2 * f_uhz);
      return LIMIT_W'(half - 64'd1);
   endfunction

endpackage

// File: rtl/melody_rom.sv
// Combinational 16-entry song table; contents come from a packed parameter.
module melody_rom
   import melody_pkg::*;
#(
   parameter logic [MAX_LEN*ENTRY_W-1:0] TABLE = DEFAULT_SONG
) (
   input  logic [3:0] index,
   output entry_t     entry
);

   assign entry = TABLE[{index, 3'b000} +: ENTRY_W];

endmodule

// File: rtl/melody_sequencer.sv
// Steps through the song table, driving the divider limit and tone gate note by note,
// with optional inter-note gaps, looping and abort.
module melody_sequencer
   import melody_pkg::*;
#(
   parameter int unsigned CLK_HZ      = 100000000,
   parameter int unsigned BEAT_CYCLES = 25000000,
   parameter int unsigned GAP_CYCLES  = 1000000,
   parameter int unsigned SONG_LEN    = 16,
   parameter logic [MAX_LEN*ENTRY_W-1:0] SONG = DEFAULT_SONG
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               start,
   input  logic               stop,
   input  logic               loop_en,
   output logic [LIMIT_W-1:0] limit,
   output logic               tone_en,
   output logic               busy,
   output logic [3:0]         note_index,
   output logic               done,
   output state_t             fsm_state
);

   localparam logic [31:0] BEAT_LOAD = 32'(BEAT_CYCLES);
   localparam logic [31:0] GAP_LOAD  = (GAP_CYCLES == 0) ? 32'd0 : 32'(GAP_CYCLES - 1);
   localparam logic [4:0]  LEN       = 5'(SONG_LEN);

   state_t             state;
   logic [31:0]        cnt;
   entry_t             first_entry;
   entry_t             next_entry;
   entry_t             load_entry;
   logic [4:0]         next_pos;
   logic               song_end;
   logic               advance;
   logic [LIMIT_W-1:0] load_limit;
   logic               load_tone;
   logic [31:0]        load_cnt;
   logic [LIMIT_W-1:0] limit_lut [16];

   // Limits are elaboration-time constants; no divider is built.
   for (genvar i = 0; i < 16; i++) begin : g_lut
      assign limit_lut[i] = note_limit(4'(i), 64'(CLK_HZ));
   end

   melody_rom #(.TABLE(SONG)) u_rom_first (
      .index (4'd0),
      .entry (first_entry)
   );

   melody_rom #(.TABLE(SONG)) u_rom_next (
      .index (next_pos[3:0]),
      .entry (next_entry)
   );

   always_comb begin
      next_pos   = {1'b0, note_index} + 5'd1;
      song_end   = (next_pos >= LEN) || (next_entry.dur == '0);
      advance    = ((state == GAP) && (cnt == '0)) ||
                   ((state == PLAY) && (cnt == '0) && (GAP_CYCLES == 0));
      // Idle start and a song wrap both load entry 0.
      load_entry = ((state == IDLE) || song_end) ? first_entry : next_entry;
      load_limit = limit_lut[load_entry.code];
      load_tone  = is_tone(load_entry.code);
      load_cnt   = 32'(load_entry.dur) * BEAT_LOAD - 32'd1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         cnt        <= '0;
         limit      <= '0;
         tone_en    <= 1'b0;
         busy       <= 1'b0;
         note_index <= '0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         if (stop) begin
            state      <= IDLE;
            cnt        <= '0;
            tone_en    <= 1'b0;
            busy       <= 1'b0;
            note_index <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     if (first_entry.dur == '0) begin
                        done <= 1'b1;
                     end else begin
                        state      <= PLAY;
                        busy       <= 1'b1;
                        note_index <= '0;
                        limit      <= load_limit;
                        tone_en    <= load_tone;
                        cnt        <= load_cnt;
                     end
                  end
               end
               PLAY, GAP: begin
                  if (advance) begin
                     if (song_end && !loop_en) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        tone_en    <= 1'b0;
                        note_index <= '0;
                        done       <= 1'b1;
                     end else begin
                        state      <= PLAY;
                        note_index <= song_end ? 4'd0 : next_pos[3:0];
                        limit      <= load_limit;
                        tone_en    <= load_tone;
                        cnt        <= load_cnt;
                     end
                  end else if ((state == PLAY) && (cnt == '0)) begin
                     state   <= GAP;
                     tone_en <= 1'b0;
                     cnt     <= GAP_LOAD;
                  end else begin
                     cnt <= cnt - 32'd1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign fsm_state = state;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: directed vector table, hand sequences for corner cases,
// and random start/stop/loop traffic against a note-timeline model.
module tb_melody_sequencer;
   import melody_pkg::*;

   localparam int R_BEAT = 2;
   localparam int R_GAP  = 1;
   localparam logic [27:0] LA = 28'd113635;

   localparam logic [127:0] SONG_A = {104'h0, 8'h00, 8'h01, 8'hA2};
   localparam logic [127:0] SONG_R = {8'h42, 8'hF1, 8'h21, 8'h11, 8'hB1, 8'h92, 8'h81, 8'h73,
                                      8'h61, 8'h51, 8'hE2, 8'h13, 8'hC1, 8'h01, 8'h32, 8'hA1};
   localparam logic [127:0] SONG_Z = {96'h0, 8'h00, 8'h81, 8'h52, 8'h11};
   localparam logic [127:0] SONG_E = {120'h0, 8'hA0};

   logic clock = 1'b0;
   logic reset_n;
   always #5 clock = ~clock;

   logic a_start, a_stop, a_loop, a_tone, a_busy, a_done;
   logic r_start, r_stop, r_loop, r_tone, r_busy, r_done;
   logic z_start, z_stop, z_loop, z_tone, z_busy, z_done;
   logic e_start, e_stop, e_loop, e_tone, e_busy, e_done;
   logic [27:0] a_limit, r_limit, z_limit, e_limit;
   logic [3:0]  a_idx, r_idx, z_idx, e_idx;
   state_t      a_state, r_state, z_state, e_state;

   melody_sequencer #(.BEAT_CYCLES(4), .GAP_CYCLES(2), .SONG(SONG_A)) u_a (
      .clock(clock), .reset_n(reset_n), .start(a_start), .stop(a_stop), .loop_en(a_loop),
      .limit(a_limit), .tone_en(a_tone), .busy(a_busy), .note_index(a_idx), .done(a_done),
      .fsm_state(a_state));

   melody_sequencer #(.BEAT_CYCLES(R_BEAT), .GAP_CYCLES(R_GAP), .SONG(SONG_R)) u_r (
      .clock(clock), .reset_n(reset_n), .start(r_start), .stop(r_stop), .loop_en(r_loop),
      .limit(r_limit), .tone_en(r_tone), .busy(r_busy), .note_index(r_idx), .done(r_done),
      .fsm_state(r_state));

   melody_sequencer #(.BEAT_CYCLES(1), .GAP_CYCLES(0), .SONG(SONG_Z)) u_z (
      .clock(clock), .reset_n(reset_n), .start(z_start), .stop(z_stop), .loop_en(z_loop),
      .limit(z_limit), .tone_en(z_tone), .busy(z_busy), .note_index(z_idx), .done(z_done),
      .fsm_state(z_state));

   melody_sequencer #(.BEAT_CYCLES(1), .GAP_CYCLES(0), .SONG(SONG_E)) u_e (
      .clock(clock), .reset_n(reset_n), .start(e_start), .stop(e_stop), .loop_en(e_loop),
      .limit(e_limit), .tone_en(e_tone), .busy(e_busy), .note_index(e_idx), .done(e_done),
      .fsm_state(e_state));

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
      end
   endtask

   // Observation word: {limit, tone_en, busy, note_index, done}
   typedef struct packed {
      logic [27:0] limit;
      logic        tone;
      logic        busy;
      logic [3:0]  idx;
      logic        done;
   } obs_t;

   function automatic logic [27:0] ref_limit(input int code);
      real f;
      real x;
      if (code < 1 || code > 12) return 28'd0;
      f = 440.0 * (2.0 ** (real'(code - 10) / 12.0));
      x = 100000000.0 / (2.0 * f);
      return 28'($rtoi(x + 0.5) - 1);
   endfunction

   // ---------------- timeline model for u_r ----------------
   logic [7:0] song_r [16];
   obs_t tl[$];
   obs_t cur;
   int   done_seen;
   logic [15:0] idx_seen;

   task automatic build_pass();
      for (int k = 0; k < 16; k++) begin
         int   code;
         int   dur;
         obs_t o;
         code = int'(song_r[k][7:4]);
         dur  = int'(song_r[k][3:0]);
         if (dur == 0) break;
         o.limit = ref_limit(code);
         o.tone  = (code >= 1 && code <= 12);
         o.busy  = 1'b1;
         o.idx   = 4'(k);
         o.done  = 1'b0;
         repeat (dur * R_BEAT) tl.push_back(o);
         o.tone = 1'b0;
         repeat (R_GAP) tl.push_back(o);
      end
   endtask

   task automatic model_step(input logic s, input logic p, input logic l);
      if (p) begin
         tl.delete();
         cur.tone = 1'b0; cur.busy = 1'b0; cur.idx = '0; cur.done = 1'b0;
      end else if (tl.size() > 0) begin
         cur = tl.pop_front();
      end else if (cur.busy) begin
         if (l) begin
            build_pass();
            cur = tl.pop_front();
         end else begin
            cur.tone = 1'b0; cur.busy = 1'b0; cur.idx = '0; cur.done = 1'b1;
         end
      end else begin
         cur.done = 1'b0;
         if (s) begin
            build_pass();
            if (tl.size() > 0) cur = tl.pop_front();
            else cur.done = 1'b1;
         end
      end
   endtask

   task automatic r_cycle(input logic s, input logic p, input logic l);
      obs_t act;
      r_start = s; r_stop = p; r_loop = l;
      @(posedge clock);
      model_step(s, p, l);
      #1;
      act = {r_limit, r_tone, r_busy, r_idx, r_done};
      check("r_timeline", 64'(act), 64'(cur));
      if (r_done) done_seen++;
      if (r_busy) idx_seen[r_idx] = 1'b1;
   endtask

   // ---------------- directed vector table for u_a ----------------
   typedef struct {
      logic        start;
      logic        stop;
      logic        loop_en;
      logic [27:0] limit;
      logic        tone;
      logic        busy;
      logic [3:0]  idx;
      logic        done;
   } vec_t;
   vec_t vecs[$];

   task automatic add(input int n, input logic s, input logic p, input logic l, input logic [27:0] lim,
                      input logic t, input logic b, input logic [3:0] i, input logic d);
      vec_t v;
      v.start = s; v.stop = p; v.loop_en = l; v.limit = lim; v.tone = t; v.busy = b; v.idx = i; v.done = d;
      repeat (n) vecs.push_back(v);
   endtask

   initial begin
      logic [127:0] song_tmp;
      int zc[4];
      int zi[4];
      obs_t act;
      obs_t exp;

      song_tmp = SONG_R;
      for (int k = 0; k < 16; k++) song_r[k] = song_tmp[k*8 +: 8];
      cur = '0;

      // Basic play: A4 for 2 beats, gap, REST 1 beat, gap, done.
      add(1, 1, 0, 0, LA,    1, 1, 0, 0);
      add(7, 0, 0, 0, LA,    1, 1, 0, 0);
      add(2, 0, 0, 0, LA,    0, 1, 0, 0);
      add(6, 0, 0, 0, 28'd0, 0, 1, 1, 0);
      add(1, 0, 0, 0, 28'd0, 0, 0, 0, 1);
      add(1, 0, 0, 0, 28'd0, 0, 0, 0, 0);
      // Looping: wraps to entry 0, then stop during the second beat.
      add(1, 1, 0, 1, LA,    1, 1, 0, 0);
      add(7, 0, 0, 1, LA,    1, 1, 0, 0);
      add(2, 0, 0, 1, LA,    0, 1, 0, 0);
      add(6, 0, 0, 1, 28'd0, 0, 1, 1, 0);
      add(5, 0, 0, 1, LA,    1, 1, 0, 0);
      add(1, 0, 1, 1, LA,    0, 0, 0, 0);
      add(2, 0, 0, 0, LA,    0, 0, 0, 0);
      // start and stop together while idle: stop wins.
      add(1, 1, 1, 0, LA,    0, 0, 0, 0);
      add(2, 0, 0, 0, LA,    0, 0, 0, 0);

      zc = '{1, 5, 5, 8};
      zi = '{0, 1, 1, 2};

      reset_n = 1'b0;
      {a_start, a_stop, a_loop, r_start, r_stop, r_loop} = '0;
      {z_start, z_stop, z_loop, e_start, e_stop, e_loop} = '0;
      repeat (2) @(negedge clock);
      check("reset_limit", 64'(a_limit), 64'd0);
      check("reset_tone",  64'(a_tone),  64'd0);
      check("reset_busy",  64'(a_busy),  64'd0);
      check("reset_idx",   64'(a_idx),   64'd0);
      check("reset_done",  64'(a_done),  64'd0);
      check("reset_state", 64'(a_state), 64'(IDLE));
      reset_n = 1'b1;

      // Asynchronous reset in the middle of a note.
      @(negedge clock);
      a_start = 1'b1;
      @(negedge clock);
      a_start = 1'b0;
      repeat (3) @(negedge clock);
      check("midplay_tone", 64'(a_tone), 64'd1);
      #2 reset_n = 1'b0;
      #1;
      check("async_limit", 64'(a_limit), 64'd0);
      check("async_tone",  64'(a_tone),  64'd0);
      check("async_busy",  64'(a_busy),  64'd0);
      check("async_idx",   64'(a_idx),   64'd0);
      check("async_done",  64'(a_done),  64'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);

      for (int i = 0; i < vecs.size(); i++) begin
         a_start = vecs[i].start; a_stop = vecs[i].stop; a_loop = vecs[i].loop_en;
         @(posedge clock);
         #1;
         act = {a_limit, a_tone, a_busy, a_idx, a_done};
         exp = {vecs[i].limit, vecs[i].tone, vecs[i].busy, vecs[i].idx, vecs[i].done};
         check($sformatf("vec%0d", i), 64'(act), 64'(exp));
         @(negedge clock);
      end
      {a_start, a_stop, a_loop} = '0;

      // No gap: notes follow back to back with the tone never dropping.
      z_start = 1'b1;
      for (int j = 0; j < 5; j++) begin
         @(posedge clock);
         #1;
         z_start = 1'b0;
         act = {z_limit, z_tone, z_busy, z_idx, z_done};
         if (j < 4) exp = {ref_limit(zc[j]), 1'b1, 1'b1, 4'(zi[j]), 1'b0};
         else       exp = {ref_limit(8), 1'b0, 1'b0, 4'd0, 1'b1};
         check($sformatf("nogap%0d", j), 64'(act), 64'(exp));
      end

      // Empty song: done pulses, busy never rises.
      @(negedge clock);
      e_start = 1'b1;
      @(posedge clock);
      #1;
      e_start = 1'b0;
      check("empty_done", 64'({e_busy, e_tone, e_done}), 64'b001);
      for (int j = 0; j < 3; j++) begin
         @(posedge clock);
         #1;
         check("empty_after", 64'({e_busy, e_done}), 64'b00);
      end

      // Full 16-entry table without looping.
      done_seen = 0;
      idx_seen  = '0;
      r_cycle(1'b1, 1'b0, 1'b0);
      repeat (75) r_cycle(1'b0, 1'b0, 1'b0);
      check("full_idx_seen", 64'(idx_seen), 64'hFFFF);
      check("full_done_cnt", 64'(done_seen), 64'd1);
      check("full_end_idx", 64'(r_idx), 64'd0);

      // Random start/stop/loop traffic.
      begin
         logic lp;
         lp = 1'b0;
         for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) lp = ~lp;
            r_cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 149) == 0), lp);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
